scarv_cop_issue: RTL and testbench
==================================

# scarv_cop_issue

Single-entry issue stage of the coprocessor, sitting directly downstream of `scarv_cop_idecode`. It accepts an instruction from the host CPU, latches the decoder outputs into an issue register, and dispatches the instruction to the functional units. It also runs the 16-cycle register-file clear for init instructions, enforces an FU timeout, and holds a response for the CPU until the CPU accepts it.

## Interface
- `FU_TIMEOUT`, default 255: max ISSUE cycles awaiting `fu_idone` before abort; 8-bit, must be ≥1.
- `g_clk` in 1: clock; all state updates on the rising edge.
- `g_rst` in 1: reset. One clock; reset is synchronous and active-high.
- `cpu_insn_req` in 1: CPU offers an instruction; the encoding is already at the decoder input.
- `cpu_insn_ack` out 1: instruction accepted this cycle.
- `cpu_rs1` in 32: GPR rs1 value accompanying the request.
- `id_exception`, `id_cprs_init`, `id_wb_h`, `id_wb_b` in 1 each: decoder outputs.
- `id_class` in 9, `id_subclass` in 16, `id_pw` in 3: decoder outputs.
- `id_crs1`, `id_crs2`, `id_crs3`, `id_crd`, `id_crd1`, `id_crd2` in 4 each; `id_rd` in 5; `id_imm` in 32: decoder outputs.
- `is_*` out, same widths as the `id_*` inputs except `id_exception` and `id_cprs_init`, plus `is_rs1_val` out 32: latched issue register.
- `fu_ivalid` out 1: issue register valid for FUs; `is_class` selects the consuming FU.
- `fu_idone` in 1: FU finished.
- `fu_error` in 1: FU fault, sampled with `fu_idone`.
- `fu_rd_wen` in 1, `fu_rd_wdata` in 32: GPR writeback, sampled with `fu_idone`.
- `crf_init_wen` out 1, `crf_init_addr` out 4: register-file clear port.
- `cpu_rsp_valid` out 1, `cpu_rsp_ready` in 1: response handshake.
- `cpu_rsp_status` out 3: 0 OK, 1 illegal, 2 FU error, 3 timeout.
- `cpu_rsp_wen` out 1, `cpu_rsp_rd` out 5, `cpu_rsp_data` out 32: GPR writeback to the CPU.
- `cop_busy` out 1: state is not IDLE.

## Operation
- States: IDLE, ISSUE, INIT, RESP.
- **Accept.** `cpu_insn_ack = cpu_insn_req & (state==IDLE) & !g_rst`, combinational. On ack, all `id_*` fields and `cpu_rs1` are latched into the `is_*` registers.
- **IDLE, on ack:**
  - to RESP with status 1 if `id_exception` or `id_class==0`;
  - otherwise to INIT if `id_cprs_init`;
  - otherwise to ISSUE.
  - Precedence is exception > class==0 > init > issue.
- **ISSUE.**
  - `fu_ivalid=1`; the cycle counter starts at 0 and increments each ISSUE cycle.
  - On `fu_idone`: capture `fu_rd_wen`/`fu_rd_wdata`. Status is 2 if `fu_error`, else 0. Go to RESP.
  - If the counter reaches `FU_TIMEOUT` without `fu_idone`: status 3, `wen=0`, go to RESP.
  - `fu_idone` in the same cycle as the timeout wins.
  - `fu_idone` outside ISSUE is ignored.
- **INIT.**
  - `crf_init_wen=1`; `crf_init_addr` steps 0,1,…,15, one per cycle.
  - After addr 15: status 0, `wen=0`, go to RESP.
  - Exactly 16 write cycles.
- **RESP.**
  - `cpu_rsp_valid=1`; `cpu_rsp_rd = is_rd`; `cpu_rsp_wen`/`cpu_rsp_data` as captured, with data forced to 0 when `wen=0`.
  - Response fields stay stable until `cpu_rsp_ready`, then go to IDLE.
  - No acceptance in the handshake cycle.
- `is_*` registers change only on ack and hold their values through RESP.
- **Reset** (synchronous, any state, mid-operation included):
  - state IDLE, all outputs 0, every `is_*` register 0, counters 0;
  - the in-flight instruction is discarded with no response.
  - FUs must treat `fu_ivalid` falling as abort.

## Timing
- Accept in cycle N.
- **ISSUE path:** `fu_ivalid` high from N+1. With `fu_idone` at N+k (k≥1), `cpu_rsp_valid` is high at N+k+1. With `cpu_rsp_ready` already high, IDLE at N+k+2 and the next ack is possible at N+k+2.
- **Illegal path:** `cpu_rsp_valid` at N+1; no `fu_ivalid` pulse.
- **INIT path:** `crf_init_wen` at N+1..N+16 (addr 0..15); `cpu_rsp_valid` at N+17.
- **Timeout:** `fu_ivalid` high at N+1..N+`FU_TIMEOUT`; status 3 response at N+`FU_TIMEOUT`+1.
- Throughput: at most one instruction in flight. `cop_busy` is high from N+1 until the cycle after the response handshake.

## Test plan
- **Reset:** assert `g_rst` 2 cycles with `cpu_insn_req=1` → `cpu_insn_ack=0`, all outputs 0. Release → ack the same cycle.
- **Padd issue:** class PACKED_ARITH, `id_rd=5`, `cpu_rs1=0xDEADBEEF`.
  - `fu_idone` at N+3 with wen=1, data=0x12345678 → `fu_ivalid` at N+1..N+3, `is_rs1_val=0xDEADBEEF`.
  - Response at N+4: status 0, rd 5, data 0x12345678.
  - Hold `cpu_rsp_ready=0` for 3 cycles → all fields stable.
- **Illegal:** `id_exception=1` → no `fu_ivalid`; status 1 at N+1. Repeat with class=0 → status 1.
- **Init:** `id_cprs_init=1` → `crf_init_addr` 0..15 at N+1..N+16; response status 0 at N+17 with `wen=0`.
- **Timeout / error:**
  - `FU_TIMEOUT=4`, FU silent → status 3 at N+5.
  - `fu_idone` on the 4th ISSUE cycle → status 0.
  - `fu_error=1` with done → status 2.
- **Mid-op reset:** reset during ISSUE cycle 2 → `fu_ivalid` 0 next cycle, no response; new request accepted right after reset releases.

Source files
------------

// File: rtl/scarv_cop_issue.sv
// ---------------------------------------------------------------------------
// scarv_cop_issue
//
// Single-entry issue stage of the coprocessor, directly downstream of the
// instruction decoder. The stage has four jobs:
//   - accept one instruction from the host CPU and latch the decoder fields
//     and the rs1 GPR value into the issue register (is_*);
//   - dispatch it to the functional units (fu_ivalid) and wait for
//     fu_idone, aborting with a timeout status after FU_TIMEOUT cycles;
//   - for register-file init instructions, sweep crf_init_addr over 0..15
//     with crf_init_wen high, one address per cycle;
//   - hold a response for the CPU until the CPU takes it.
// Only one instruction is in flight at a time.
//
// Ports
//   g_clk, g_rst            clock; synchronous active-high reset
//   cpu_insn_req/ack        instruction offer / combinational accept
//   cpu_rs1                 rs1 GPR value travelling with the request
//   id_*                    decoder outputs for the offered instruction
//   is_*, is_rs1_val        issue register; changes only on accept
//   fu_ivalid               issue register valid for the FUs (is_class picks
//                           the FU); a falling edge means abort
//   fu_idone/fu_error       FU completion and fault flag
//   fu_rd_wen/fu_rd_wdata   GPR writeback, sampled with fu_idone
//   crf_init_wen/addr       register-file clear port
//   cpu_rsp_*               response to the CPU (status 0 OK, 1 illegal,
//                           2 FU error, 3 timeout)
//   cop_busy                stage is not idle
//   dbg_state               0 idle, 1 issue, 2 init, 3 response
//
// Handshakes: cpu_insn_req/cpu_insn_ack transfers an instruction in any
// cycle where both are high. cpu_rsp_valid/cpu_rsp_ready transfers the
// response in any cycle where both are high; until then every cpu_rsp_*
// field stays stable and no new instruction is accepted.
// ---------------------------------------------------------------------------
module scarv_cop_issue #(
    parameter int unsigned FU_TIMEOUT = 255
) (
    input  logic        g_clk,
    input  logic        g_rst,

    input  logic        cpu_insn_req,
    output logic        cpu_insn_ack,
    input  logic [31:0] cpu_rs1,

    input  logic        id_exception,
    input  logic        id_cprs_init,
    input  logic        id_wb_h,
    input  logic        id_wb_b,
    input  logic [8:0]  id_class,
    input  logic [15:0] id_subclass,
    input  logic [2:0]  id_pw,
    input  logic [3:0]  id_crs1,
    input  logic [3:0]  id_crs2,
    input  logic [3:0]  id_crs3,
    input  logic [3:0]  id_crd,
    input  logic [3:0]  id_crd1,
    input  logic [3:0]  id_crd2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_imm,

    output logic        is_wb_h,
    output logic        is_wb_b,
    output logic [8:0]  is_class,
    output logic [15:0] is_subclass,
    output logic [2:0]  is_pw,
    output logic [3:0]  is_crs1,
    output logic [3:0]  is_crs2,
    output logic [3:0]  is_crs3,
    output logic [3:0]  is_crd,
    output logic [3:0]  is_crd1,
    output logic [3:0]  is_crd2,
    output logic [4:0]  is_rd,
    output logic [31:0] is_imm,
    output logic [31:0] is_rs1_val,

    output logic        fu_ivalid,
    input  logic        fu_idone,
    input  logic        fu_error,
    input  logic        fu_rd_wen,
    input  logic [31:0] fu_rd_wdata,

    output logic        crf_init_wen,
    output logic [3:0]  crf_init_addr,

    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ready,
    output logic [2:0]  cpu_rsp_status,
    output logic        cpu_rsp_wen,
    output logic [4:0]  cpu_rsp_rd,
    output logic [31:0] cpu_rsp_data,

    output logic        cop_busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_INIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] RSP_OK      = 3'd0;
    localparam logic [2:0] RSP_ILLEGAL = 3'd1;
    localparam logic [2:0] RSP_FU_ERR  = 3'd2;
    localparam logic [2:0] RSP_TIMEOUT = 3'd3;

    // The counter holds the number of ISSUE cycles already spent before the
    // current one, so the last permitted cycle sees FU_TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(FU_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  issue_cnt;
    logic [3:0]  init_addr;

    logic [2:0]  rsp_status_q;
    logic        rsp_wen_q;
    logic [31:0] rsp_data_q;

    logic        rsp_load;
    logic [2:0]  rsp_status_nxt;
    logic        rsp_wen_nxt;
    logic [31:0] rsp_data_nxt;

    // -----------------------------------------------------------------------
    // Next state, accept and response capture
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        rsp_load       = 1'b0;
        rsp_status_nxt = RSP_OK;
        rsp_wen_nxt    = 1'b0;
        rsp_data_nxt   = '0;
        // Reset gates the ack so an instruction offered during reset is
        // never reported as taken.
        cpu_insn_ack   = cpu_insn_req && (state == ST_IDLE) && !g_rst;

        case (state)
            ST_IDLE: begin
                if (cpu_insn_ack) begin
                    // Exception and the null class both report illegal and
                    // never reach the FUs or the init sweep.
                    if (id_exception || (id_class == 9'd0)) begin
                        state_nxt      = ST_RESP;
                        rsp_load       = 1'b1;
                        rsp_status_nxt = RSP_ILLEGAL;
                    end else if (id_cprs_init) begin
                        state_nxt = ST_INIT;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                // A completion in the final permitted cycle beats the timeout.
                if (fu_idone) begin
                    state_nxt      = ST_RESP;
                    rsp_load       = 1'b1;
                    rsp_status_nxt = fu_error ? RSP_FU_ERR : RSP_OK;
                    rsp_wen_nxt    = fu_rd_wen;
                    rsp_data_nxt   = fu_rd_wen ? fu_rd_wdata : 32'd0;
                end else if (issue_cnt == TIMEOUT_LAST) begin
                    state_nxt      = ST_RESP;
                    rsp_load       = 1'b1;
                    rsp_status_nxt = RSP_TIMEOUT;
                end
            end

            ST_INIT: begin
                if (init_addr == 4'hF) begin
                    state_nxt      = ST_RESP;
                    rsp_load       = 1'b1;
                    rsp_status_nxt = RSP_OK;
                end
            end

            ST_RESP: begin
                if (cpu_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, counters, response and issue registers
    // -----------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state        <= ST_IDLE;
            issue_cnt    <= '0;
            init_addr    <= '0;
            rsp_status_q <= RSP_OK;
            rsp_wen_q    <= 1'b0;
            rsp_data_q   <= '0;
            is_wb_h      <= 1'b0;
            is_wb_b      <= 1'b0;
            is_class     <= '0;
            is_subclass  <= '0;
            is_pw        <= '0;
            is_crs1      <= '0;
            is_crs2      <= '0;
            is_crs3      <= '0;
            is_crd       <= '0;
            is_crd1      <= '0;
            is_crd2      <= '0;
            is_rd        <= '0;
            is_imm       <= '0;
            is_rs1_val   <= '0;
        end else begin
            state <= state_nxt;

            // Both counters sit at zero outside their own state, so every
            // entry starts a fresh count without an explicit clear.
            if (state == ST_ISSUE) begin
                issue_cnt <= issue_cnt + 8'd1;
            end else begin
                issue_cnt <= '0;
            end

            if (state == ST_INIT) begin
                init_addr <= init_addr + 4'd1;
            end else begin
                init_addr <= '0;
            end

            if (rsp_load) begin
                rsp_status_q <= rsp_status_nxt;
                rsp_wen_q    <= rsp_wen_nxt;
                rsp_data_q   <= rsp_data_nxt;
            end

            if (cpu_insn_ack) begin
                is_wb_h     <= id_wb_h;
                is_wb_b     <= id_wb_b;
                is_class    <= id_class;
                is_subclass <= id_subclass;
                is_pw       <= id_pw;
                is_crs1     <= id_crs1;
                is_crs2     <= id_crs2;
                is_crs3     <= id_crs3;
                is_crd      <= id_crd;
                is_crd1     <= id_crd1;
                is_crd2     <= id_crd2;
                is_rd       <= id_rd;
                is_imm      <= id_imm;
                is_rs1_val  <= cpu_rs1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign fu_ivalid     = (state == ST_ISSUE);
    assign crf_init_wen  = (state == ST_INIT);
    assign crf_init_addr = init_addr;

    // Response fields read as zero whenever no response is being offered.
    assign cpu_rsp_valid  = (state == ST_RESP);
    assign cpu_rsp_status = cpu_rsp_valid ? rsp_status_q : 3'd0;
    assign cpu_rsp_wen    = cpu_rsp_valid & rsp_wen_q;
    assign cpu_rsp_rd     = cpu_rsp_valid ? is_rd : 5'd0;
    assign cpu_rsp_data   = cpu_rsp_valid ? rsp_data_q : 32'd0;

    assign cop_busy  = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_scarv_cop_issue.sv
// ---------------------------------------------------------------------------
// tb_scarv_cop_issue
//
// Directed bench for the coprocessor issue stage, built with FU_TIMEOUT=4.
// A behavioural model tracks the phase of the in-flight instruction and its
// age in cycles since acceptance, and a compare process checks every output
// against it on each falling edge. The driver tasks additionally pin
// hand-computed latencies, statuses and data for each directed case.
// ---------------------------------------------------------------------------
module tb_scarv_cop_issue;

  localparam int unsigned FU_TO = 4;
  // Nonzero class code standing in for the packed-arithmetic FU.
  localparam logic [8:0] CLS_PACKED_ARITH = 9'h004;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic g_rst = 1'b1;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ DUT signals
  logic        cpu_insn_req = 1'b0;
  logic        cpu_insn_ack;
  logic [31:0] cpu_rs1 = '0;
  logic        id_exception = 1'b0, id_cprs_init = 1'b0;
  logic        id_wb_h = 1'b0, id_wb_b = 1'b0;
  logic [8:0]  id_class = '0;
  logic [15:0] id_subclass = '0;
  logic [2:0]  id_pw = '0;
  logic [3:0]  id_crs1 = '0, id_crs2 = '0, id_crs3 = '0;
  logic [3:0]  id_crd = '0, id_crd1 = '0, id_crd2 = '0;
  logic [4:0]  id_rd = '0;
  logic [31:0] id_imm = '0;
  logic        is_wb_h, is_wb_b;
  logic [8:0]  is_class;
  logic [15:0] is_subclass;
  logic [2:0]  is_pw;
  logic [3:0]  is_crs1, is_crs2, is_crs3, is_crd, is_crd1, is_crd2;
  logic [4:0]  is_rd;
  logic [31:0] is_imm, is_rs1_val;
  logic        fu_ivalid;
  logic        fu_idone = 1'b0, fu_error = 1'b0, fu_rd_wen = 1'b0;
  logic [31:0] fu_rd_wdata = '0;
  logic        crf_init_wen;
  logic [3:0]  crf_init_addr;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ready = 1'b0;
  logic [2:0]  cpu_rsp_status;
  logic        cpu_rsp_wen;
  logic [4:0]  cpu_rsp_rd;
  logic [31:0] cpu_rsp_data;
  logic        cop_busy;
  logic [1:0]  dbg_state;

  scarv_cop_issue #(.FU_TIMEOUT(FU_TO)) dut (
    .g_clk(clk), .g_rst(g_rst),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack), .cpu_rs1(cpu_rs1),
    .id_exception(id_exception), .id_cprs_init(id_cprs_init),
    .id_wb_h(id_wb_h), .id_wb_b(id_wb_b), .id_class(id_class),
    .id_subclass(id_subclass), .id_pw(id_pw),
    .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3),
    .id_crd(id_crd), .id_crd1(id_crd1), .id_crd2(id_crd2),
    .id_rd(id_rd), .id_imm(id_imm),
    .is_wb_h(is_wb_h), .is_wb_b(is_wb_b), .is_class(is_class),
    .is_subclass(is_subclass), .is_pw(is_pw),
    .is_crs1(is_crs1), .is_crs2(is_crs2), .is_crs3(is_crs3),
    .is_crd(is_crd), .is_crd1(is_crd1), .is_crd2(is_crd2),
    .is_rd(is_rd), .is_imm(is_imm), .is_rs1_val(is_rs1_val),
    .fu_ivalid(fu_ivalid), .fu_idone(fu_idone), .fu_error(fu_error),
    .fu_rd_wen(fu_rd_wen), .fu_rd_wdata(fu_rd_wdata),
    .crf_init_wen(crf_init_wen), .crf_init_addr(crf_init_addr),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_status(cpu_rsp_status), .cpu_rsp_wen(cpu_rsp_wen),
    .cpu_rsp_rd(cpu_rsp_rd), .cpu_rsp_data(cpu_rsp_data),
    .cop_busy(cop_busy), .dbg_state(dbg_state)
  );

  logic [90:0] dut_is;
  assign dut_is = {is_class, is_subclass, is_pw, is_wb_h, is_wb_b, is_crs1, is_crs2,
                   is_crs3, is_crd, is_crd1, is_crd2, is_rd, is_imm};

  // ------------------------------------------------------------ scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  // Phase numbering matches the documented dbg_state encoding.
  localparam int P_IDLE = 0, P_FU = 1, P_INIT = 2, P_RESP = 3;
  int          m_phase = P_IDLE;
  int          m_age   = 0;      // cycles spent in FU or init phase so far
  logic [90:0] m_is    = '0;
  logic [31:0] m_rs1   = '0;
  logic [2:0]  m_st    = '0;
  logic        m_wen   = 1'b0;
  logic [31:0] m_data  = '0;

  function automatic void respond(input logic [2:0] st, input logic wen, input logic [31:0] d);
    m_phase = P_RESP;
    m_st    = st;
    m_wen   = wen;
    m_data  = wen ? d : 32'd0;
  endfunction

  always @(posedge clk) begin
    if (g_rst) begin
      m_phase = P_IDLE; m_age = 0; m_is = '0; m_rs1 = '0;
      m_st = '0; m_wen = 1'b0; m_data = '0;
    end else begin
      case (m_phase)
        P_IDLE: if (cpu_insn_req) begin
          m_is  = {id_class, id_subclass, id_pw, id_wb_h, id_wb_b, id_crs1, id_crs2,
                   id_crs3, id_crd, id_crd1, id_crd2, id_rd, id_imm};
          m_rs1 = cpu_rs1;
          m_age = 0;
          if (id_exception || id_class == 9'd0) respond(3'd1, 1'b0, 32'd0);
          else if (id_cprs_init)                m_phase = P_INIT;
          else                                  m_phase = P_FU;
        end
        P_FU: begin
          m_age++;
          if (fu_idone)            respond(fu_error ? 3'd2 : 3'd0, fu_rd_wen, fu_rd_wdata);
          else if (m_age == FU_TO) respond(3'd3, 1'b0, 32'd0);
        end
        P_INIT: begin
          m_age++;
          if (m_age == 16) respond(3'd0, 1'b0, 32'd0);
        end
        default: if (cpu_rsp_ready) m_phase = P_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ compare
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ack", 32'(cpu_insn_ack), 32'(cpu_insn_req && m_phase == P_IDLE && !g_rst));
      chk("fu_ivalid", 32'(fu_ivalid), 32'(m_phase == P_FU));
      chk("crf_init_wen", 32'(crf_init_wen), 32'(m_phase == P_INIT));
      if (m_phase == P_INIT) chk("crf_init_addr", 32'(crf_init_addr), 32'(m_age));
      chk("rsp_valid", 32'(cpu_rsp_valid), 32'(m_phase == P_RESP));
      chk("cop_busy", 32'(cop_busy), 32'(m_phase != P_IDLE));
      chk("dbg_state", 32'(dbg_state), 32'(m_phase));
      chk_wide("is_fields", 128'(dut_is), 128'(m_is));
      chk("is_rs1_val", is_rs1_val, m_rs1);
      if (m_phase == P_RESP) begin
        chk("rsp_status", 32'(cpu_rsp_status), 32'(m_st));
        chk("rsp_wen", 32'(cpu_rsp_wen), 32'(m_wen));
        chk("rsp_data", cpu_rsp_data, m_data);
        chk("rsp_rd", 32'(cpu_rsp_rd), 32'(m_is[36:32]));
      end
    end
  end

  // ------------------------------------------------------------ driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [8:0] cls, input bit exc, input bit init,
                            input logic [4:0] rd, input logic [31:0] rs1);
    id_class = cls; id_exception = exc; id_cprs_init = init; id_rd = rd; cpu_rs1 = rs1;
    id_subclass = 16'($urandom); id_pw = 3'($urandom); id_imm = $urandom;
    id_wb_h = 1'($urandom); id_wb_b = 1'($urandom);
    id_crs1 = 4'($urandom); id_crs2 = 4'($urandom); id_crs3 = 4'($urandom);
    id_crd = 4'($urandom); id_crd1 = 4'($urandom); id_crd2 = 4'($urandom);
  endtask

  // Issue one instruction in an idle cycle and follow it to the handshake.
  // done_at: ISSUE cycle (1-based) that raises fu_idone, 0 for never.
  // exp_lat: cycle after accept at which the response must appear.
  task automatic do_insn(input string nm, input logic [8:0] cls, input bit exc, input bit init,
                         input logic [4:0] rd, input logic [31:0] rs1,
                         input int done_at, input bit err, input bit wen, input logic [31:0] data,
                         input int exp_lat, input logic [2:0] exp_st, input bit exp_wen,
                         input logic [31:0] exp_data, input int exp_nfu, input int exp_ninit,
                         input int hold, input bit keep_req);
    int w, k, nfu, ninit;
    bit found;
    set_fields(cls, exc, init, rd, rs1);
    cpu_insn_req = 1'b1;
    w = 0;
    @(negedge clk);
    while (!cpu_insn_ack && w < 10) begin
      w++;
      @(negedge clk);
    end
    chk({nm, "_accept_wait"}, 32'(w), 32'd0);
    step();
    cpu_insn_req = 1'b0;
    k = 1; found = 1'b0; nfu = 0; ninit = 0;
    while (!found && k <= 40) begin
      fu_idone = (k == done_at); fu_error = err; fu_rd_wen = wen; fu_rd_wdata = data;
      @(negedge clk);
      if (cpu_rsp_valid) found = 1'b1;
      else begin
        if (fu_ivalid) nfu++;
        if (crf_init_wen) begin
          chk({nm, "_init_addr"}, 32'(crf_init_addr), 32'(ninit));
          ninit++;
        end
        step();
        k++;
      end
    end
    fu_idone = 1'b0; fu_error = 1'b0; fu_rd_wen = 1'b0;
    chk({nm, "_latency"}, 32'(k), 32'(exp_lat));
    chk({nm, "_status"}, 32'(cpu_rsp_status), 32'(exp_st));
    chk({nm, "_wen"}, 32'(cpu_rsp_wen), 32'(exp_wen));
    chk({nm, "_data"}, cpu_rsp_data, exp_data);
    chk({nm, "_rd"}, 32'(cpu_rsp_rd), 32'(rd));
    chk({nm, "_ivalid_cycles"}, 32'(nfu), 32'(exp_nfu));
    chk({nm, "_init_cycles"}, 32'(ninit), 32'(exp_ninit));
    // While the CPU stalls, stray FU completions must not disturb anything.
    repeat (hold) begin
      fu_idone = 1'b1; fu_error = 1'b1; fu_rd_wen = 1'b1; fu_rd_wdata = $urandom;
      step();
      fu_idone = 1'b0; fu_error = 1'b0; fu_rd_wen = 1'b0;
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(cpu_rsp_valid), 32'd1);
      chk({nm, "_hold_status"}, 32'(cpu_rsp_status), 32'(exp_st));
      chk({nm, "_hold_data"}, cpu_rsp_data, exp_data);
      chk({nm, "_hold_rd"}, 32'(cpu_rsp_rd), 32'(rd));
    end
    cpu_rsp_ready = 1'b1;
    cpu_insn_req  = keep_req;
    #1;
    chk({nm, "_no_ack_in_rsp"}, 32'(cpu_insn_ack), 32'd0);
    step();
    cpu_rsp_ready = 1'b0;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    // Reset held two cycles with a request pending.
    set_fields(CLS_PACKED_ARITH, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF);
    cpu_insn_req = 1'b1;
    step();
    cmp_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", 32'(cpu_insn_ack), 32'd0);
      chk("rst_ivalid", 32'(fu_ivalid), 32'd0);
      chk("rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      chk("rst_busy", 32'(cop_busy), 32'd0);
      chk("rst_is_rs1", is_rs1_val, 32'd0);
      step();
    end
    g_rst = 1'b0;

    // Packed add: done on ISSUE cycle 3, response at N+4, CPU stalls 3 cycles.
    do_insn("padd", CLS_PACKED_ARITH, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF,
            3, 1'b0, 1'b1, 32'h12345678, 4, 3'd0, 1'b1, 32'h12345678, 3, 0, 3, 1'b1);
    chk("padd_is_rs1", is_rs1_val, 32'hDEADBEEF);
    chk("padd_is_rd", 32'(is_rd), 32'd5);

    // Back-to-back: accepted the cycle after the handshake.
    do_insn("illegal_exc", CLS_PACKED_ARITH, 1'b1, 1'b0, 5'd7, 32'h1,
            0, 1'b0, 1'b0, 32'd0, 1, 3'd1, 1'b0, 32'd0, 0, 0, 0, 1'b0);
    // Class 0 outranks the init flag.
    do_insn("illegal_cls0", 9'd0, 1'b0, 1'b1, 5'd9, 32'h2,
            0, 1'b0, 1'b0, 32'd0, 1, 3'd1, 1'b0, 32'd0, 0, 0, 1, 1'b0);
    do_insn("init", 9'h010, 1'b0, 1'b1, 5'd3, 32'h3,
            0, 1'b0, 1'b0, 32'd0, 17, 3'd0, 1'b0, 32'd0, 0, 16, 0, 1'b0);
    do_insn("timeout", CLS_PACKED_ARITH, 1'b0, 1'b0, 5'd11, 32'h4,
            0, 1'b0, 1'b1, 32'hCAFEF00D, 5, 3'd3, 1'b0, 32'd0, 4, 0, 0, 1'b0);
    do_insn("done_last", 9'h001, 1'b0, 1'b0, 5'd12, 32'h5,
            4, 1'b0, 1'b1, 32'hA5A50001, 5, 3'd0, 1'b1, 32'hA5A50001, 4, 0, 0, 1'b0);
    do_insn("fu_error", 9'h100, 1'b0, 1'b0, 5'd31, 32'h6,
            2, 1'b1, 1'b0, 32'hFFFFFFFF, 3, 3'd2, 1'b0, 32'd0, 2, 0, 1, 1'b0);
    do_insn("wen0_data", 9'h002, 1'b0, 1'b0, 5'd1, 32'h7,
            1, 1'b0, 1'b0, 32'h55AA55AA, 2, 3'd0, 1'b0, 32'd0, 1, 0, 0, 1'b0);

    // Reset during ISSUE cycle 2, then a new request right after release.
    set_fields(CLS_PACKED_ARITH, 1'b0, 1'b0, 5'd4, 32'h8);
    cpu_insn_req = 1'b1;
    @(negedge clk);
    chk("midrst_accept", 32'(cpu_insn_ack), 32'd1);
    step();
    cpu_insn_req = 1'b0;
    step();
    g_rst = 1'b1;
    @(negedge clk);
    chk("midrst_ivalid_c2", 32'(fu_ivalid), 32'd1);
    step();
    g_rst = 1'b0;
    set_fields(CLS_PACKED_ARITH, 1'b1, 1'b0, 5'd6, 32'h9);
    cpu_insn_req = 1'b1;
    @(negedge clk);
    chk("midrst_ivalid_after", 32'(fu_ivalid), 32'd0);
    chk("midrst_no_rsp", 32'(cpu_rsp_valid), 32'd0);
    chk("midrst_is_rs1", is_rs1_val, 32'd0);
    chk("midrst_new_ack", 32'(cpu_insn_ack), 32'd1);
    step();
    cpu_insn_req = 1'b0;
    @(negedge clk);
    chk("midrst_new_rsp", 32'(cpu_rsp_valid), 32'd1);
    chk("midrst_new_status", 32'(cpu_rsp_status), 32'd1);
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
    @(negedge clk);
    chk("final_idle", 32'(cop_busy), 32'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
